// File: rtl/ball_round_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ball_round_sequencer_pkg
//  Description : Shared types and widths for the pinball round sequencer.
//                Holds the game-state encoding, which doubles as the HUD
//                state_code, and the portal index type.
//  Revision    : 1.0 - initial release
// ============================================================================
package ball_round_sequencer_pkg;

    localparam int COORD_W     = 11;  // playfield coordinate width
    localparam int CHARGE_W    = 8;   // plunger charge counter width
    localparam int LIVES_W     = 2;   // remaining-balls width
    localparam int FRAME_CNT_W = 8;   // width of the frame countdown timers

    // The encoding is visible on state_code, so values are pinned explicitly.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READY     = 3'd1,
        ST_CHARGE    = 3'd2,
        ST_PLAY      = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_e;

    // Bit position of a portal within portal_req.
    typedef enum logic {
        PORTAL_A = 1'b0,
        PORTAL_B = 1'b1
    } portal_e;

endpackage : ball_round_sequencer_pkg
`default_nettype wire

// File: rtl/ball_round_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ball_round_sequencer_if
//  Description : Signal bundle between the round sequencer and the rest of
//                the pinball system (keys, playfield hits, mover controls).
//                slave  : the sequencer side
//                master : the environment side (keys, hit detectors, mover)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ball_round_sequencer_if;

    import ball_round_sequencer_pkg::*;

    // towards the sequencer
    logic                   startOfFrame;
    logic                   key_launch;
    logic                   key_newGame;
    logic                   drain_hit;
    logic [1:0]             portal_req;
    logic [COORD_W-1:0]     portalA_x;
    logic [COORD_W-1:0]     portalA_y;
    logic [COORD_W-1:0]     portalB_x;
    logic [COORD_W-1:0]     portalB_y;
    logic                   boost_req;

    // from the sequencer
    logic                   start;
    logic                   loss;
    logic                   teleport;
    logic [COORD_W-1:0]     forced_x;
    logic [COORD_W-1:0]     forced_y;
    logic                   speed_var;
    logic [31:0]            forced_speed;
    logic [LIVES_W-1:0]     lives;
    logic                   game_over;
    logic [CHARGE_W-1:0]    charge_level;
    logic [2:0]             state_code;

    modport slave (
        input  startOfFrame, key_launch, key_newGame, drain_hit, portal_req,
               portalA_x, portalA_y, portalB_x, portalB_y, boost_req,
        output start, loss, teleport, forced_x, forced_y, speed_var,
               forced_speed, lives, game_over, charge_level, state_code
    );

    modport master (
        output startOfFrame, key_launch, key_newGame, drain_hit, portal_req,
               portalA_x, portalA_y, portalB_x, portalB_y, boost_req,
        input  start, loss, teleport, forced_x, forced_y, speed_var,
               forced_speed, lives, game_over, charge_level, state_code
    );

endinterface : ball_round_sequencer_if
`default_nettype wire

// File: rtl/ball_round_sequencer_frame_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : frame_down_counter
//  Description : Frame-based countdown timer. Loads a value, decrements once
//                per startOfFrame pulse and holds at zero.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                clear_i         - force count to zero (highest after reset)
//                load_i          - load load_value_i (wins over a decrement)
//                load_value_i    - value to load
//                sof_i           - frame pulse, decrement enable
//                zero_o          - count is zero (registered state)
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_down_counter #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clear_i,
    input  wire logic             load_i,
    input  wire logic [WIDTH-1:0] load_value_i,
    input  wire logic             sof_i,
    output logic                  zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_value_i;
        end else if (sof_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule : frame_down_counter
`default_nettype wire

// File: rtl/ball_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ball_round_sequencer
//  Description : Pinball game-round controller. Sequences new game, plunger
//                charge, launch, play, drain and game over; during play it
//                arbitrates two portals onto the mover's teleport path and
//                times bumper speed boosts.
//  Ports       : clk      - system clock
//                reset    - synchronous active-high reset
//                ctrl_io  - sequencer side of ball_round_sequencer_if
//                           (keys, hits, portal coords in; mover controls,
//                           lives, charge and state out)
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_round_sequencer
    import ball_round_sequencer_pkg::*;
#(
    parameter int INITIAL_LIVES   = 3,
    parameter int MAX_CHARGE      = 160,
    parameter int DRAIN_FRAMES    = 8,
    parameter int COOLDOWN_FRAMES = 20,
    parameter int BOOST_FRAMES    = 30,
    parameter int BOOST_SPEED     = 400
) (
    input  wire logic              clk,
    input  wire logic              reset,
    ball_round_sequencer_if.slave  ctrl_io
);

    state_e                 state_q, state_d;
    logic                   launch_prev_q;
    logic                   newgame_prev_q;
    logic [LIVES_W-1:0]     lives_q, lives_d;
    logic [CHARGE_W-1:0]    charge_q, charge_d;
    logic                   teleport_q, teleport_d;
    logic [COORD_W-1:0]     forced_x_q, forced_x_d;
    logic [COORD_W-1:0]     forced_y_q, forced_y_d;
    portal_e                last_grant_q, last_grant_d;

    logic                   launch_rise;
    logic                   newgame_rise;
    logic                   grant_valid;
    portal_e                grant_sel;
    logic                   drain_load;
    logic                   cool_load;
    logic                   boost_load;
    logic                   play_exit;
    logic                   drain_zero;
    logic                   cool_zero;
    logic                   boost_zero;

    assign launch_rise  = ctrl_io.key_launch  & ~launch_prev_q;
    assign newgame_rise = ctrl_io.key_newGame & ~newgame_prev_q;

    // Cooldown and boost only live inside PLAY; any path out of PLAY
    // (including the drain that beats a same-cycle boost) wipes them.
    assign play_exit = (state_d != ST_PLAY);

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        charge_d     = charge_q;
        teleport_d   = 1'b0;
        forced_x_d   = forced_x_q;
        forced_y_d   = forced_y_q;
        last_grant_d = last_grant_q;
        drain_load   = 1'b0;
        cool_load    = 1'b0;
        boost_load   = 1'b0;
        grant_valid  = 1'b0;
        grant_sel    = PORTAL_A;

        // Round-robin only matters on a tie; a lone request always wins.
        case (ctrl_io.portal_req)
            2'b01: begin
                grant_valid = 1'b1;
                grant_sel   = PORTAL_A;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_sel   = PORTAL_B;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_sel   = (last_grant_q == PORTAL_A) ? PORTAL_B : PORTAL_A;
            end
            default: ;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (newgame_rise) begin
                    state_d = ST_READY;
                    lives_d = LIVES_W'(INITIAL_LIVES);
                end
            end

            ST_READY: begin
                if (launch_rise) begin
                    state_d  = ST_CHARGE;
                    charge_d = '0;
                end
            end

            ST_CHARGE: begin
                if (ctrl_io.startOfFrame && (charge_q < CHARGE_W'(MAX_CHARGE))) begin
                    charge_d = charge_q + CHARGE_W'(1);
                end
                // Leave on the same cycle the charge saturates.
                if (!ctrl_io.key_launch || (charge_d == CHARGE_W'(MAX_CHARGE))) begin
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (ctrl_io.drain_hit) begin
                    state_d    = ST_DRAIN;
                    drain_load = 1'b1;
                    lives_d    = (lives_q != '0) ? (lives_q - LIVES_W'(1)) : '0;
                end else begin
                    if (grant_valid && cool_zero) begin
                        teleport_d   = 1'b1;
                        last_grant_d = grant_sel;
                        cool_load    = 1'b1;
                        if (grant_sel == PORTAL_B) begin
                            forced_x_d = ctrl_io.portalB_x;
                            forced_y_d = ctrl_io.portalB_y;
                        end else begin
                            forced_x_d = ctrl_io.portalA_x;
                            forced_y_d = ctrl_io.portalA_y;
                        end
                    end
                    if (ctrl_io.boost_req) begin
                        boost_load = 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                if (drain_zero) begin
                    state_d = (lives_q == '0) ? ST_GAME_OVER : ST_READY;
                end
            end

            ST_GAME_OVER: begin
                if (newgame_rise) begin
                    state_d = ST_READY;
                    lives_d = LIVES_W'(INITIAL_LIVES);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            launch_prev_q  <= 1'b0;
            newgame_prev_q <= 1'b0;
            lives_q        <= LIVES_W'(INITIAL_LIVES);
            charge_q       <= '0;
            teleport_q     <= 1'b0;
            forced_x_q     <= '0;
            forced_y_q     <= '0;
            last_grant_q   <= PORTAL_B;   // so the first tie goes to A
        end else begin
            state_q        <= state_d;
            launch_prev_q  <= ctrl_io.key_launch;
            newgame_prev_q <= ctrl_io.key_newGame;
            lives_q        <= lives_d;
            charge_q       <= charge_d;
            teleport_q     <= teleport_d;
            forced_x_q     <= forced_x_d;
            forced_y_q     <= forced_y_d;
            last_grant_q   <= last_grant_d;
        end
    end

    frame_down_counter #(.WIDTH(FRAME_CNT_W)) u_drain_cnt (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (1'b0),
        .load_i       (drain_load),
        .load_value_i (FRAME_CNT_W'(DRAIN_FRAMES)),
        .sof_i        (ctrl_io.startOfFrame),
        .zero_o       (drain_zero)
    );

    frame_down_counter #(.WIDTH(FRAME_CNT_W)) u_cool_cnt (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (play_exit),
        .load_i       (cool_load),
        .load_value_i (FRAME_CNT_W'(COOLDOWN_FRAMES)),
        .sof_i        (ctrl_io.startOfFrame),
        .zero_o       (cool_zero)
    );

    frame_down_counter #(.WIDTH(FRAME_CNT_W)) u_boost_cnt (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (play_exit),
        .load_i       (boost_load),
        .load_value_i (FRAME_CNT_W'(BOOST_FRAMES)),
        .sof_i        (ctrl_io.startOfFrame),
        .zero_o       (boost_zero)
    );

    assign ctrl_io.start        = (state_q == ST_CHARGE);
    assign ctrl_io.loss         = (state_q == ST_DRAIN);
    assign ctrl_io.game_over    = (state_q == ST_GAME_OVER);
    assign ctrl_io.teleport     = teleport_q;
    assign ctrl_io.forced_x     = forced_x_q;
    assign ctrl_io.forced_y     = forced_y_q;
    assign ctrl_io.speed_var    = ~boost_zero;
    assign ctrl_io.forced_speed = 32'(BOOST_SPEED);
    assign ctrl_io.lives        = lives_q;
    assign ctrl_io.charge_level = charge_q;
    assign ctrl_io.state_code   = state_q;

endmodule : ball_round_sequencer
`default_nettype wire

// File: tb/tb_ball_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ball_round_sequencer
//  Description : Directed self-checking bench for ball_round_sequencer.
//                Frames are 4 clocks long: one startOfFrame cycle followed
//                by three idle cycles. Inputs change and outputs are sampled
//                1 time unit after the rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_round_sequencer;

    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_READY = 32'd1;
    localparam logic [31:0] S_CHRG  = 32'd2;
    localparam logic [31:0] S_PLAY  = 32'd3;
    localparam logic [31:0] S_DRAIN = 32'd4;
    localparam logic [31:0] S_GOVER = 32'd5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    ball_round_sequencer_if bus ();

    ball_round_sequencer #(
        .INITIAL_LIVES   (3),
        .MAX_CHARGE      (160),
        .DRAIN_FRAMES    (8),
        .COOLDOWN_FRAMES (20),
        .BOOST_FRAMES    (30),
        .BOOST_SPEED     (400)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl_io (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        repeat (3) tick();
    endtask

    // READY -> CHARGE -> PLAY (launch released) -> DRAIN -> expiry.
    task automatic play_and_drain();
        bus.key_launch = 1'b1;
        tick();
        bus.key_launch = 1'b0;
        tick();
        check_val("release_to_play", 32'(bus.state_code), S_PLAY);
        bus.drain_hit = 1'b1;
        tick();
        bus.drain_hit = 1'b0;
        repeat (8) frame_pulse();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bus.startOfFrame = 1'b0;
        bus.key_launch   = 1'b0;
        bus.key_newGame  = 1'b0;
        bus.drain_hit    = 1'b0;
        bus.portal_req   = 2'b00;
        bus.portalA_x    = 11'd240;
        bus.portalA_y    = 11'd60;
        bus.portalB_x    = 11'd300;
        bus.portalB_y    = 11'd90;
        bus.boost_req    = 1'b0;

        // ---------------- reset values ----------------
        repeat (2) tick();
        check_val("rst_state",  32'(bus.state_code), S_IDLE);
        check_val("rst_lives",  32'(bus.lives), 32'd3);
        check_val("rst_charge", 32'(bus.charge_level), 32'd0);
        check_val("rst_fx",     32'(bus.forced_x), 32'd0);
        check_val("rst_fy",     32'(bus.forced_y), 32'd0);
        check_val("rst_outs",   32'({bus.start, bus.loss, bus.teleport, bus.speed_var, bus.game_over}), 32'd0);
        check_val("fspeed",     bus.forced_speed, 32'd400);
        reset = 1'b0;
        tick();

        // ---------------- reset mid-charge ----------------
        bus.key_newGame = 1'b1;
        tick();
        bus.key_newGame = 1'b0;
        check_val("ng_ready", 32'(bus.state_code), S_READY);
        bus.key_launch = 1'b1;
        tick();
        check_val("chg_state", 32'(bus.state_code), S_CHRG);
        check_val("chg_start", 32'(bus.start), 32'd1);
        check_val("chg_zero",  32'(bus.charge_level), 32'd0);
        repeat (50) frame_pulse();
        check_val("chg_50", 32'(bus.charge_level), 32'd50);
        reset = 1'b1;
        tick();
        check_val("midrst_state",  32'(bus.state_code), S_IDLE);
        check_val("midrst_start",  32'(bus.start), 32'd0);
        check_val("midrst_charge", 32'(bus.charge_level), 32'd0);
        check_val("midrst_lives",  32'(bus.lives), 32'd3);
        reset = 1'b0;
        bus.key_launch = 1'b0;
        tick();

        // ---------------- charge saturation ----------------
        bus.key_newGame = 1'b1;
        tick();
        bus.key_newGame = 1'b0;
        bus.key_launch  = 1'b1;
        tick();
        repeat (159) frame_pulse();
        check_val("sat_159",       32'(bus.charge_level), 32'd159);
        check_val("sat_159_state", 32'(bus.state_code), S_CHRG);
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        check_val("sat_160",       32'(bus.charge_level), 32'd160);
        check_val("sat_play",      32'(bus.state_code), S_PLAY);
        check_val("sat_start_off", 32'(bus.start), 32'd0);
        repeat (3) tick();
        repeat (40) frame_pulse();
        check_val("sat_hold", 32'(bus.charge_level), 32'd160);
        bus.key_launch = 1'b0;
        tick();

        // ---------------- portal arbitration ----------------
        bus.portal_req = 2'b11;
        tick();
        bus.portal_req = 2'b00;
        check_val("tp1_pulse", 32'(bus.teleport), 32'd1);
        check_val("tp1_x",     32'(bus.forced_x), 32'd240);
        check_val("tp1_y",     32'(bus.forced_y), 32'd60);
        tick();
        check_val("tp1_width", 32'(bus.teleport), 32'd0);
        repeat (10) frame_pulse();
        bus.portal_req = 2'b11;
        tick();
        bus.portal_req = 2'b00;
        check_val("cool_f10", 32'(bus.teleport), 32'd0);
        repeat (9) frame_pulse();
        bus.portal_req = 2'b10;
        tick();
        bus.portal_req = 2'b00;
        check_val("cool_f19", 32'(bus.teleport), 32'd0);
        check_val("cool_f19_x", 32'(bus.forced_x), 32'd240);
        frame_pulse();
        bus.portal_req = 2'b11;
        tick();
        bus.portal_req = 2'b00;
        check_val("tp2_pulse", 32'(bus.teleport), 32'd1);
        check_val("tp2_x",     32'(bus.forced_x), 32'd300);
        check_val("tp2_y",     32'(bus.forced_y), 32'd90);
        repeat (20) frame_pulse();
        bus.portal_req = 2'b01;
        tick();
        bus.portal_req = 2'b00;
        check_val("tp3_single_a", 32'(bus.forced_x), 32'd240);
        repeat (20) frame_pulse();
        bus.portal_req = 2'b11;
        tick();
        bus.portal_req = 2'b00;
        check_val("tp4_rr_b", 32'(bus.forced_y), 32'd90);
        tick();

        // ---------------- boost with retrigger ----------------
        frame_pulse();
        bus.boost_req = 1'b1;
        tick();
        bus.boost_req = 1'b0;
        check_val("boost_on", 32'(bus.speed_var), 32'd1);
        for (int j = 1; j <= 51; j++) begin
            bus.startOfFrame = 1'b1;
            if (j == 20) check_val("boost_f20", 32'(bus.speed_var), 32'd1);
            if (j == 31) check_val("boost_f31", 32'(bus.speed_var), 32'd1);
            if (j == 50) check_val("boost_f50", 32'(bus.speed_var), 32'd1);
            if (j == 51) check_val("boost_f51", 32'(bus.speed_var), 32'd0);
            tick();
            bus.startOfFrame = 1'b0;
            repeat (3) tick();
            if (j == 20) begin
                bus.boost_req = 1'b1;
                tick();
                bus.boost_req = 1'b0;
            end
        end

        // ---------------- drain beats portal and boost ----------------
        bus.boost_req = 1'b1;
        tick();
        bus.boost_req = 1'b0;
        check_val("pre_drain_boost", 32'(bus.speed_var), 32'd1);
        bus.drain_hit  = 1'b1;
        bus.portal_req = 2'b01;
        tick();
        bus.drain_hit  = 1'b0;
        bus.portal_req = 2'b00;
        check_val("drain_state", 32'(bus.state_code), S_DRAIN);
        check_val("drain_loss",  32'(bus.loss), 32'd1);
        check_val("drain_no_tp", 32'(bus.teleport), 32'd0);
        check_val("drain_fx",    32'(bus.forced_x), 32'd300);
        check_val("drain_lives", 32'(bus.lives), 32'd2);
        check_val("drain_boost_cut", 32'(bus.speed_var), 32'd0);
        repeat (7) frame_pulse();
        check_val("drain_f7_loss", 32'(bus.loss), 32'd1);
        frame_pulse();
        check_val("drain_end_state", 32'(bus.state_code), S_READY);
        check_val("drain_end_loss",  32'(bus.loss), 32'd0);
        bus.boost_req = 1'b1;
        tick();
        bus.boost_req = 1'b0;
        check_val("ready_no_boost", 32'(bus.speed_var), 32'd0);

        // ---------------- game over ----------------
        play_and_drain();
        check_val("d2_state", 32'(bus.state_code), S_READY);
        check_val("d2_lives", 32'(bus.lives), 32'd1);
        play_and_drain();
        check_val("go_state", 32'(bus.state_code), S_GOVER);
        check_val("go_flag",  32'(bus.game_over), 32'd1);
        check_val("go_lives", 32'(bus.lives), 32'd0);
        bus.key_newGame = 1'b1;
        tick();
        bus.key_newGame = 1'b0;
        check_val("restart_state", 32'(bus.state_code), S_READY);
        check_val("restart_lives", 32'(bus.lives), 32'd3);
        check_val("restart_go",    32'(bus.game_over), 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_ball_round_sequencer
`default_nettype wire
